carousel_rr_arbiter: RTL and testbench

CAROUSEL_RR_ARBITER -- requirements
Module: carousel_rr_arbiter

---
 rtl/carousel_rr_arbiter.sv | 98 +++++++++
 tb/tb_carousel_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carousel_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry output register with full-throughput handshake.
// Optional per-lane grant counters are built when CAROUSEL_ARB_STATS_EN is defined.

`ifdef CAROUSEL_ARB_STATS_EN
module carousel_arb_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (inc && count != 16'hFFFF) count <= count + 16'd1;
  end
endmodule
`endif

module carousel_rr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in        [NUM_REQ],
  input  logic             data_in_valid  [NUM_REQ],
  output logic             data_in_ready  [NUM_REQ],
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic [IDX_W-1:0] grant_idx,
  output logic [15:0]      grant_count    [NUM_REQ]
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W:0]   k;
  logic             found;
  logic             load;

  // Rotating search: first valid lane at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = {1'b0, ptr} + (IDX_W+1)'(i);
      if (k >= (IDX_W+1)'(NUM_REQ)) k = k - (IDX_W+1)'(NUM_REQ);
      if (!found && data_in_valid[k[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = k[IDX_W-1:0];
      end
    end
  end

  assign load           = found && (state == EMPTY || data_out_ready) && !rst;
  assign data_out_valid = (state == FULL);

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++)
      data_in_ready[j] = load && (win == IDX_W'(j));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      data_out  <= '0;
      grant_idx <= '0;
      ptr       <= '0;
    end else if (load) begin
      state     <= FULL;
      data_out  <= data_in[win];
      grant_idx <= win;
      ptr       <= (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
    end else if (state == FULL && data_out_ready) begin
      state     <= EMPTY;
    end
  end

`ifdef CAROUSEL_ARB_STATS_EN
  for (genvar j = 0; j < NUM_REQ; j++) begin : g_cnt
    carousel_arb_cnt u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (data_in_ready[j]),
      .count (grant_count[j])
    );
  end
`else
  for (genvar j = 0; j < NUM_REQ; j++) begin : g_cnt
    assign grant_count[j] = '0;
  end
`endif

endmodule

// File: tb/tb_carousel_rr_arbiter.sv
// Bench for carousel_rr_arbiter: queue/array reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_carousel_rr_arbiter;
  localparam int W  = 8;
  localparam int N  = 3;
  localparam int IW = 2;
`ifdef CAROUSEL_ARB_STATS_EN
  localparam int          SAT_N   = 70000;
  localparam logic [15:0] SAT_EXP = 16'hFFFF;
`else
  localparam int          SAT_N   = 20;
  localparam logic [15:0] SAT_EXP = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  data_in       [N];
  logic          data_in_valid [N];
  logic          data_in_ready [N];
  logic [W-1:0]  data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [IW-1:0] grant_idx;
  logic [15:0]   grant_count   [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carousel_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .grant_idx      (grant_idx),
    .grant_count    (grant_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: round-robin pointer, one-word register, saturating counts.
  int          mptr  = 0;
  bit          mfull = 1'b0;
  logic [W-1:0] mdata = '0;
  int          midx  = 0;
  int unsigned mcnt [N] = '{default: 0};
  int          mw;
  bit          ml;

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int l = (mptr + i) % N;
      if (data_in_valid[l] === 1'b1) return l;
    end
    return -1;
  endfunction

  function automatic bit mload();
    return (rst === 1'b0) && (pick() >= 0) && (!mfull || data_out_ready === 1'b1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mptr = 0; mfull = 1'b0; mdata = '0; midx = 0;
      for (int j = 0; j < N; j++) mcnt[j] = 0;
    end else begin
      mw = pick();
      ml = mload();
      if (ml) begin
        mdata = data_in[mw];
        midx  = mw;
        mfull = 1'b1;
        mptr  = (mw + 1) % N;
`ifdef CAROUSEL_ARB_STATS_EN
        if (mcnt[mw] < 65535) mcnt[mw]++;
`endif
      end else if (mfull && data_out_ready) begin
        mfull = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, plus an in-order word scoreboard.
  logic [IW+W-1:0] sbq [$];
  logic [IW+W-1:0] sbe;
  int ew;
  bit el;

  always @(negedge clk) begin
    if (rst) sbq.delete();
    chk("m_valid", data_out_valid, mfull);
    if (mfull) begin
      chk("m_data", data_out, mdata);
      chk("m_idx", grant_idx, midx);
    end
    ew = pick();
    el = mload();
    for (int j = 0; j < N; j++) chk("m_ready", data_in_ready[j], el && ew == j);
    for (int j = 0; j < N; j++) chk("m_count", grant_count[j], mcnt[j]);
    if (!rst && data_out_valid && data_out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got word %0h with nothing accepted", data_out);
      end else begin
        sbe = sbq.pop_front();
        if ({grant_idx, data_out} !== sbe) begin
          errors++;
          $display("FAIL sb_order: got %0h expected %0h", {grant_idx, data_out}, sbe);
        end
      end
    end
    for (int j = 0; j < N; j++)
      if (!rst && data_in_valid[j] && data_in_ready[j]) sbq.push_back({IW'(j), data_in[j]});
  end

  task automatic drive(input logic [N-1:0] v);
    for (int j = 0; j < N; j++) data_in_valid[j] = v[j];
  endtask

  function automatic logic [N-1:0] rdy();
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[j] = data_in_ready[j];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    data_out_ready = 1'b0;
    for (int j = 0; j < N; j++) data_in[j] = '0;
    drive(3'b111);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", data_out_valid, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_idx", grant_idx, 2'd0);
    chk("rst_ready", rdy(), 3'b000);
    rst = 1'b0;

    // All lanes valid, sink always ready: 0,1,2,0,1,2
    for (int j = 0; j < N; j++) data_in[j] = 8'h10 + 8'(j);
    data_out_ready = 1'b1;
    #1 chk("a_ready0", rdy(), 3'b001);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("a_valid", data_out_valid, 1'b1);
      chk("a_idx", grant_idx, k % 3);
      chk("a_data", data_out, 8'h10 + k % 3);
    end

    // ptr -> 1 via lane 0, then lanes 0,1 valid: 1 first, then 0
    drive(3'b001);
    step();
    chk("b_idx0", grant_idx, 2'd0);
    drive(3'b011);
    step();
    chk("b_idx1", grant_idx, 2'd1);
    step();
    chk("b_idx2", grant_idx, 2'd0);
    drive(3'b000);
    step();
    chk("b_drain", data_out_valid, 1'b0);

    // Backpressure for 5 cycles while all lanes valid
    drive(3'b111);
    step();
    chk("c_idx", grant_idx, 2'd1);
    chk("c_data", data_out, 8'h11);
    data_out_ready = 1'b0;
    repeat (5) begin
      #1 chk("c_ready_hold", rdy(), 3'b000);
      step();
      chk("c_data_hold", data_out, 8'h11);
      chk("c_idx_hold", grant_idx, 2'd1);
    end
    data_out_ready = 1'b1;
    #1 chk("c_ready_resume", rdy(), 3'b100);
    step();
    chk("c_idx_resume", grant_idx, 2'd2);
    chk("c_data_resume", data_out, 8'h12);
    drive(3'b000);
    step();
    chk("c_drain", data_out_valid, 1'b0);

    // Only lane 2 valid from EMPTY, then search restarts at lane 0
    data_in[2] = 8'hA5;
    drive(3'b100);
    step();
    chk("d_valid", data_out_valid, 1'b1);
    chk("d_data", data_out, 8'hA5);
    chk("d_idx", grant_idx, 2'd2);
    data_in[0] = 8'h5A;
    drive(3'b101);
    #1 chk("d_ready", rdy(), 3'b001);
    step();
    chk("d_idx_next", grant_idx, 2'd0);
    chk("d_data_next", data_out, 8'h5A);
    drive(3'b000);
    step();

    // Reset while FULL discards the held word immediately
    data_out_ready = 1'b0;
    data_in[0] = 8'h3C;
    drive(3'b001);
    step();
    chk("e_full", data_out, 8'h3C);
    drive(3'b000);
    #1 rst = 1'b1;
    #1;
    chk("e_rst_valid", data_out_valid, 1'b0);
    chk("e_rst_data", data_out, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    data_out_ready = 1'b1;
    repeat (3) begin
      step();
      chk("e_no_3c", data_out_valid, 1'b0);
    end

    // Repeated grants to lane 1: counters saturate when built, else stay 0
    data_in[1] = 8'h77;
    drive(3'b010);
    repeat (SAT_N) @(posedge clk);
    #1;
    chk("f_cnt0", grant_count[0], 16'h0000);
    chk("f_cnt1", grant_count[1], SAT_EXP);
    chk("f_cnt2", grant_count[2], 16'h0000);
    drive(3'b000);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
